// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the PC sequencer: FSM states, redirect sources
// ordered by priority, and the default reset/exception addresses.
package pcpu_pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD
    } pc_state_e;

    // Numeric order is the priority order: a larger value wins.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JMP  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_EXC  = 2'd3
    } redir_src_e;

    localparam logic [31:0] PC_RESET_DEFAULT      = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_EXC_VECTOR_DEFAULT = 32'h0000_0180;

    function automatic logic [31:0] align_tgt(input logic [31:0] t);
        return {t[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bus between the PC sequencer (master) and the core/imem (slave).
interface pc_sequencer_if;
    logic [31:0] pc;
    logic        stall;
    logic        imem_req;
    logic        imem_ack;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        exc_req;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        flush_if;
    logic        flush_id;
    logic        redirect_pending;

    modport master (
        input  pc, stall, imem_ack, br_taken, br_target, jmp_valid, jmp_target, exc_req,
        output imem_req, pc_write, pc_next, flush_if, flush_id, redirect_pending
    );

    modport slave (
        output pc, stall, imem_ack, br_taken, br_target, jmp_valid, jmp_target, exc_req,
        input  imem_req, pc_write, pc_next, flush_if, flush_id, redirect_pending
    );
endinterface

// File: rtl/pc_sequencer_redirect_buf.sv
// Single-entry pending redirect register; a capture replaces the held entry
// only when its priority is equal or higher.
module pc_redirect_buf
    import pcpu_pc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  redir_src_e  cap_src_i,
    input  logic [31:0] cap_target_i,
    input  logic        consume_i,
    output redir_src_e  pend_src_o,
    output logic [31:0] pend_target_o
);

    redir_src_e  src_q, src_d;
    logic [31:0] tgt_q, tgt_d;

    always_comb begin
        src_d = src_q;
        tgt_d = tgt_q;
        if (consume_i) begin
            src_d = SRC_NONE;
            tgt_d = '0;
        end else if (cap_src_i != SRC_NONE && cap_src_i >= src_q) begin
            src_d = cap_src_i;
            tgt_d = cap_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q <= SRC_NONE;
            tgt_q <= '0;
        end else begin
            src_q <= src_d;
            tgt_q <= tgt_d;
        end
    end

    assign pend_src_o    = src_q;
    assign pend_target_o = tgt_q;

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: BOOT/FETCH/HOLD control with prioritised redirects.
// Exception redirects exist only when PC_SEQ_EXC_EN is defined.
module pc_sequencer
    import pcpu_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = PC_RESET_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = PC_EXC_VECTOR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    pc_sequencer_if.master     bus
);

    pc_state_e   state_q, state_d;
    redir_src_e  live_src, pend_src, applied_src, cap_src;
    logic [31:0] live_tgt, pend_tgt, applied_tgt;
    logic        exc_live;
    logic        imem_req_c, pc_write_c, in_boot;

`ifdef PC_SEQ_EXC_EN
    assign exc_live = bus.exc_req;
`else
    logic unused_exc;
    assign exc_live   = 1'b0;
    assign unused_exc = ^{bus.exc_req, EXC_VECTOR};
`endif

    always_comb begin
        live_src = SRC_NONE;
        live_tgt = '0;
        if (exc_live) begin
            live_src = SRC_EXC;
            live_tgt = align_tgt(EXC_VECTOR);
        end else if (bus.br_taken) begin
            live_src = SRC_BR;
            live_tgt = align_tgt(bus.br_target);
        end else if (bus.jmp_valid) begin
            live_src = SRC_JMP;
            live_tgt = align_tgt(bus.jmp_target);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        imem_req_c = 1'b0;
        pc_write_c = 1'b0;
        case (state_q)
            ST_BOOT: begin
                pc_write_c = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    if (bus.stall) state_d = ST_HOLD;
                    else           pc_write_c = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!bus.stall) state_d = ST_FETCH;
            end
            default: state_d = ST_BOOT;
        endcase
        // Reset is sampled synchronously but must dominate the outputs in its own cycle.
        if (reset) begin
            imem_req_c = 1'b0;
            pc_write_c = 1'b1;
        end
    end

    assign in_boot     = reset || (state_q == ST_BOOT);
    assign applied_src = (live_src != SRC_NONE) ? live_src : pend_src;
    assign applied_tgt = (live_src != SRC_NONE) ? live_tgt : pend_tgt;
    assign cap_src     = (!pc_write_c && !reset) ? live_src : SRC_NONE;

    pc_redirect_buf u_buf (
        .clk           (clk),
        .reset         (reset),
        .cap_src_i     (cap_src),
        .cap_target_i  (live_tgt),
        .consume_i     (pc_write_c),
        .pend_src_o    (pend_src),
        .pend_target_o (pend_tgt)
    );

    assign bus.imem_req         = imem_req_c;
    assign bus.pc_write         = pc_write_c;
    assign bus.pc_next          = in_boot ? RESET_PC
                                : (applied_src != SRC_NONE) ? applied_tgt : bus.pc + 32'd4;
    assign bus.flush_if         = !in_boot && pc_write_c && (applied_src != SRC_NONE);
    assign bus.flush_id         = !in_boot && pc_write_c && (applied_src >= SRC_BR);
    assign bus.redirect_pending = !reset && (pend_src != SRC_NONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a priority/pending reference model queues
// expected outputs per cycle; a negedge monitor pops and compares them.
module tb_pc_sequencer;

`ifdef PC_SEQ_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] EXC_PC = 32'h0000_0180;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_sequencer_if sif ();

    pc_sequencer #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    typedef struct { logic [31:0] nxt; logic fi; logic fd; } wr_t;
    typedef struct { logic req; logic rp; logic wr; } st_t;

    wr_t wq[$];
    st_t sq[$];
    int  tests = 0;
    int  fails = 0;

    // Reference model state
    bit          m_boot, m_hold, last_wr;
    int          m_pprio;
    logic [31:0] m_ptgt, pc_r, last_nxt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_pc(input logic [31:0] v);
        last_wr  = 1'b1;
        last_nxt = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rst, input bit st, input bit ack,
                         input bit br, input logic [31:0] bt,
                         input bit jv, input logic [31:0] jt, input bit exc);
        st_t         s;
        wr_t         w;
        int          best;
        logic [31:0] btgt;
        bit          wr;
        if (last_wr) pc_r = last_nxt;
        last_wr        = 1'b0;
        reset          = rst;
        sif.pc         = pc_r;
        sif.stall      = st;
        sif.imem_ack   = ack;
        sif.br_taken   = br;
        sif.br_target  = bt;
        sif.jmp_valid  = jv;
        sif.jmp_target = jt;
        sif.exc_req    = exc;

        best = 0;
        btgt = '0;
        if (jv)           begin best = 1; btgt = {jt[31:2], 2'b00}; end
        if (br)           begin best = 2; btgt = {bt[31:2], 2'b00}; end
        if (exc && EXC_EN) begin best = 3; btgt = EXC_PC; end

        w.nxt = RST_PC; w.fi = 1'b0; w.fd = 1'b0;
        if (rst) begin
            s.req = 1'b0; s.rp = 1'b0; s.wr = 1'b1; wr = 1'b1;
            m_boot = 1'b1; m_hold = 1'b0; m_pprio = 0;
        end else if (m_boot) begin
            s.req = 1'b0; s.rp = (m_pprio != 0); s.wr = 1'b1; wr = 1'b1;
            m_boot = 1'b0;
        end else begin
            s.rp  = (m_pprio != 0);
            s.req = !m_hold;
            wr    = !m_hold && ack && !st;
            s.wr  = wr;
            if (wr) begin
                if (best > 0) begin
                    w.nxt = btgt; w.fi = 1'b1; w.fd = (best >= 2);
                end else if (m_pprio > 0) begin
                    w.nxt = m_ptgt; w.fi = 1'b1; w.fd = (m_pprio >= 2);
                end else begin
                    w.nxt = pc_r + 32'd4;
                end
                m_pprio = 0;
            end else begin
                if (best > 0 && best >= m_pprio) begin
                    m_pprio = best;
                    m_ptgt  = btgt;
                end
                if (m_hold) begin
                    if (!st) m_hold = 1'b0;
                end else if (ack) begin
                    m_hold = 1'b1;
                end
            end
        end
        sq.push_back(s);
        if (wr) begin
            wq.push_back(w);
            last_wr  = 1'b1;
            last_nxt = w.nxt;
        end
    endtask

    task automatic idle(input bit ack);
        drive(1'b0, 1'b0, ack, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    st_t mon_s;
    wr_t mon_w;
    always @(negedge clk) begin
        if (sq.size() > 0) begin
            mon_s = sq.pop_front();
            chk("imem_req", {31'd0, sif.imem_req}, {31'd0, mon_s.req});
            chk("redirect_pending", {31'd0, sif.redirect_pending}, {31'd0, mon_s.rp});
            chk("pc_write", {31'd0, sif.pc_write}, {31'd0, mon_s.wr});
            if (sif.pc_write === 1'b1) begin
                if (wq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got pc_next %08h expected no write", sif.pc_next);
                end else begin
                    mon_w = wq.pop_front();
                    chk("pc_next", sif.pc_next, mon_w.nxt);
                    chk("flush_if", {31'd0, sif.flush_if}, {31'd0, mon_w.fi});
                    chk("flush_id", {31'd0, sif.flush_id}, {31'd0, mon_w.fd});
                end
            end else if (mon_s.wr && wq.size() > 0) begin
                void'(wq.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        sif.pc = '0; sif.stall = 1'b0; sif.imem_ack = 1'b0;
        sif.br_taken = 1'b0; sif.br_target = '0;
        sif.jmp_valid = 1'b0; sif.jmp_target = '0; sif.exc_req = 1'b0;
        m_boot = 1'b1; m_hold = 1'b0; m_pprio = 0; m_ptgt = '0;
        pc_r = '0; last_wr = 1'b0; last_nxt = '0;
        tick();

        // Reset, boot, then wrap from FFFFFFFC to 0
        drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk); chk("rst_pc_next", sif.pc_next, RST_PC);
        tick();
        idle(1'b1);
        @(negedge clk); chk("boot_pc_next", sif.pc_next, RST_PC);
        chk("boot_pc_write", {31'd0, sif.pc_write}, 32'd1);
        tick();
        idle(1'b1);
        @(negedge clk); chk("first_fetch", sif.pc_next, 32'h0000_0000);
        tick();
        idle(1'b1);
        @(negedge clk); chk("second_fetch", sif.pc_next, 32'h0000_0004);
        tick();

        // Branch captured while waiting for ack, applied 3 cycles later
        set_pc(32'h0000_0010);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0043, 1'b0, '0, 1'b0);
        tick();
        idle(1'b0);
        @(negedge clk); chk("br_pending", {31'd0, sif.redirect_pending}, 32'd1);
        tick();
        idle(1'b0);
        tick();
        idle(1'b1);
        @(negedge clk);
        chk("br_apply_pc", sif.pc_next, 32'h0000_0040);
        chk("br_apply_fid", {31'd0, sif.flush_id}, 32'd1);
        tick();

        // All three live sources together
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0500, 1'b1);
        @(negedge clk); chk("prio_all", sif.pc_next, EXC_EN ? EXC_PC : 32'h0000_0300);
        tick();
        idle(1'b0);
        @(negedge clk); chk("prio_no_pend", {31'd0, sif.redirect_pending}, 32'd0);
        tick();

        // Pending overwrite order: jmp then br, and br then jmp
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0100, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, '0, 1'b0); tick();
        idle(1'b1);
        @(negedge clk); chk("jmp_then_br", sif.pc_next, 32'h0000_0200);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, '0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0100, 1'b0); tick();
        idle(1'b1);
        @(negedge clk); chk("br_then_jmp", sif.pc_next, 32'h0000_0200);
        tick();

        // Stall into HOLD, imem_req low throughout, sequential on return
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
            @(negedge clk); chk("hold_req", {31'd0, sif.imem_req}, 32'd0);
            tick();
        end
        idle(1'b1); tick();
        idle(1'b1);
        @(negedge clk); chk("hold_resume", sif.pc_next, pc_r + 32'd4);
        tick();

        // Reset while in HOLD with an exception pending
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1); tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("hold_rst_pc", sif.pc_next, RST_PC);
        chk("hold_rst_pend", {31'd0, sif.redirect_pending}, 32'd0);
        tick();
        idle(1'b1); tick();
        if (!EXC_EN) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
            @(negedge clk); chk("exc_ignored", sif.pc_next, pc_r + 32'd4);
            tick();
        end

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 7) == 0, $urandom,
                  $urandom_range(0, 5) == 0, $urandom,
                  $urandom_range(0, 9) == 0);
            tick();
        end
        idle(1'b0);
        tick();
        @(negedge clk);
        #1;
        chk("wq_drained", wq.size(), 32'd0);
        chk("sq_drained", sq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'hFFFFFFFC: value driven on pc_next during reset and BOOT, so the first sequential fetch is 0.
REQ-002 Parameter EXC_VECTOR, default 32'h00000180: exception redirect target.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  input  32  current PC register value.
REQ-006 stall  input  1  hazard-unit stall request.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_ack  input  1  fetch complete; honoured only while imem_req=1.
REQ-009 br_taken / br_target  input  1 / 32  EX-stage branch redirect.
REQ-010 jmp_valid / jmp_target  input  1 / 32  ID-stage jump redirect.
REQ-011 exc_req  input  1  exception redirect to EXC_VECTOR.
REQ-012 pc_write  output  1  PC loads pc_next at the next posedge.
REQ-013 pc_next  output  32  next PC value.
REQ-014 flush_if / flush_id  output  1 / 1  pipeline flush strobes.
REQ-015 redirect_pending  output  1  a captured redirect awaits application.

Function
REQ-016 FSM states SHALL be BOOT, FETCH and HOLD.
REQ-017 BOOT SHALL last exactly one cycle after reset deasserts, drive pc_write=1 with pc_next=RESET_PC, then go to FETCH.
REQ-018 FETCH SHALL drive imem_req=1; without imem_ack: pc_write=0, stay in FETCH.
REQ-019 FETCH with imem_ack=1 and stall=0 SHALL drive pc_write=1 that cycle (zero latency) and stay in FETCH.
REQ-020 FETCH with imem_ack=1 and stall=1 SHALL drive pc_write=0 and go to HOLD.
REQ-021 HOLD SHALL drive imem_req=0 and pc_write=0, return to FETCH on the first cycle with stall=0, and ignore imem_ack.
REQ-022 pc_next SHALL follow fixed priority: exc_req > br_taken > jmp_valid > pending redirect > pc+4.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-024 Redirect targets SHALL have bits [1:0] forced to 0.
REQ-025 A redirect arriving in a cycle with pc_write=0 SHALL be captured in the pending buffer, and redirect_pending SHALL be 1 from the next cycle.
REQ-026 A new capture SHALL overwrite the pending entry only if its priority is equal or higher; a lower-priority request SHALL be dropped.
REQ-027 The pending entry SHALL be consumed (cleared) by the next pc_write, or overridden at that pc_write by a higher-priority live request.
REQ-028 Any non-sequential pc_write SHALL assert flush_if for that cycle.
REQ-029 flush_id SHALL additionally assert when the applied source is exc or br, live or pending.
REQ-030 Live redirects coinciding with a pc_write SHALL be applied directly and not captured.

Reset
REQ-031 Reset SHALL win over every other input on any cycle, including mid-fetch and in HOLD.
REQ-032 During reset: state=BOOT, pending cleared, imem_req=0, pc_write=1, pc_next=RESET_PC, flush_if=flush_id=0, redirect_pending=0.

Configuration
REQ-033 Macro PC_SEQ_EXC_EN: when defined, exc_req behaves per REQ-022/026/029.
REQ-034 Without PC_SEQ_EXC_EN, exc_req SHALL be ignored, EXC_VECTOR SHALL be unused, and priority starts at br_taken.

Structure
REQ-035 Shared package pcpu_pc_pkg SHALL hold the FSM state enum, the redirect-source enum (NONE, JMP, BR, EXC) with priority ordering, and the default RESET_PC and EXC_VECTOR constants.
REQ-036 One sub-module, pc_redirect_buf, SHALL implement the pending register and the priority-overwrite rule.

Verification
REQ-037 Reset then release, pc=FFFFFFFC, imem_ack=1 every cycle -> BOOT pc_write with FFFFFFFC, then pc_next=00000000, then 00000004.
REQ-038 pc=00000010, imem_ack=0, br_taken=1, br_target=00000043 for 1 cycle; ack 3 cycles later -> redirect_pending=1 until then; pc_write with pc_next=00000040, flush_if=1, flush_id=1.
REQ-039 Same cycle exc_req=1, br_taken=1, jmp_valid=1 with ack -> pc_next=00000180; pending stays 0.
REQ-040 Pending jmp=00000100, then br=00000200 captured before ack -> pc_next=00000200; reversed order -> pc_next still 00000200.
REQ-041 stall=1 with ack -> HOLD, imem_req=0 for the stall duration; stall=0 -> FETCH, sequential pc+4 on the next ack.
REQ-042 reset asserted in HOLD with a pending exc -> pending cleared, pc_next=FFFFFFFC; without PC_SEQ_EXC_EN, exc_req alone -> pc_next=pc+4.
